// File: rtl/bcd_interval_timer_if.sv
// Control/status bundle for bcd_interval_timer.
// master drives enable/direction/clear/load; slave returns count and status pulses.
interface bcd_interval_timer_if #(
  parameter int NUM_DIGITS = 2
);
  logic                    enable_i;
  logic                    up_down_i;
  logic                    clear_i;
  logic                    load_i;
  logic [4*NUM_DIGITS-1:0] load_value_i;
  logic [4*NUM_DIGITS-1:0] count_o;
  logic                    tick_o;
  logic                    wrap_o;
  logic                    done_o;
  logic                    load_err_o;

  modport master (
    output enable_i, up_down_i, clear_i,
    output load_i, load_value_i,
    input  count_o, tick_o, wrap_o,
    input  done_o, load_err_o
  );

  modport slave (
    input  enable_i, up_down_i, clear_i,
    input  load_i, load_value_i,
    output count_o, tick_o, wrap_o,
    output done_o, load_err_o
  );
endinterface

// File: rtl/bcd_interval_timer.sv
// Programmable-tick N-digit BCD up/down counter, wrap or one-shot.
// Ports: CLOCK_50_I, resetn (async low), tif = control in / count+status out.
module bcd_interval_timer #(
  parameter int                      CLK_DIV    = 50000000,
  parameter int                      NUM_DIGITS = 2,
  parameter logic [4*NUM_DIGITS-1:0] MAX_BCD    = 'h59,
  parameter bit                      WRAP_EN    = 1'b1
) (
  input logic                CLOCK_50_I,
  input logic                resetn,
  bcd_interval_timer_if.slave tif
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic { RUN, DONE } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [W-1:0]    count_q, count_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            err_q, err_d;

  logic            run;
  logic            step;
  logic            at_term;
  logic            load_ok;
  logic [DW-1:0]   div_nxt;

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (r[4*i+:4] == 4'd9) begin
          r[4*i+:4] = 4'd0;
        end else begin
          r[4*i+:4] = r[4*i+:4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b) begin
        if (r[4*i+:4] == 4'd0) begin
          r[4*i+:4] = 4'd9;
        end else begin
          r[4*i+:4] = r[4*i+:4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i+:4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Divider only advances while enabled and not parked in DONE.
  assign run     = tif.enable_i && (state_q == RUN);
  assign step    = run && (div_q == DIV_LAST);
  assign div_nxt = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  assign at_term = tif.up_down_i ? (count_q == MAX_BCD)
                                 : (count_q == '0);
  // Valid BCD compares correctly as a plain unsigned number.
  assign load_ok = bcd_ok(tif.load_value_i) &&
                   (tif.load_value_i <= MAX_BCD);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (tif.clear_i) begin
      div_d   = '0;
      count_d = '0;
      state_d = RUN;
    end else if (tif.load_i) begin
      if (load_ok) begin
        count_d = tif.load_value_i;
        div_d   = '0;
        state_d = RUN;
      end else begin
        err_d = 1'b1;
        if (run) div_d = div_nxt;
      end
    end else begin
      if (run) div_d = div_nxt;
      if (step) begin
        if (at_term) begin
          wrap_d = 1'b1;
          if (WRAP_EN) begin
            tick_d  = 1'b1;
            count_d = tif.up_down_i ? '0 : MAX_BCD;
          end else begin
            state_d = DONE;
          end
        end else begin
          tick_d  = 1'b1;
          count_d = tif.up_down_i ? bcd_inc(count_q)
                                  : bcd_dec(count_q);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      div_q   <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign tif.count_o    = count_q;
  assign tif.tick_o     = tick_q;
  assign tif.wrap_o     = wrap_q;
  assign tif.done_o     = (state_q == DONE);
  assign tif.load_err_o = err_q;
endmodule

// File: tb/tb_bcd_interval_timer.sv
// Self-checking bench: three configurations driven in lockstep,
// directed sequences, a constant-vector table and a random run.
module tb_bcd_interval_timer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        en, up, clr, ld;
  logic [31:0] lv;

  bcd_interval_timer_if #(.NUM_DIGITS(2)) ifa ();
  bcd_interval_timer_if #(.NUM_DIGITS(2)) ifb ();
  bcd_interval_timer_if #(.NUM_DIGITS(4)) ifc ();

  assign ifa.enable_i = en;  assign ifa.up_down_i = up;
  assign ifa.clear_i  = clr; assign ifa.load_i    = ld;
  assign ifa.load_value_i = lv[7:0];
  assign ifb.enable_i = en;  assign ifb.up_down_i = up;
  assign ifb.clear_i  = clr; assign ifb.load_i    = ld;
  assign ifb.load_value_i = lv[7:0];
  assign ifc.enable_i = en;  assign ifc.up_down_i = up;
  assign ifc.clear_i  = clr; assign ifc.load_i    = ld;
  assign ifc.load_value_i = lv[15:0];

  bcd_interval_timer #(.CLK_DIV(4), .NUM_DIGITS(2),
    .MAX_BCD(8'h59), .WRAP_EN(1'b1))
    dut_a (.CLOCK_50_I(clk), .resetn(rst_n), .tif(ifa));
  bcd_interval_timer #(.CLK_DIV(4), .NUM_DIGITS(2),
    .MAX_BCD(8'h59), .WRAP_EN(1'b0))
    dut_b (.CLOCK_50_I(clk), .resetn(rst_n), .tif(ifb));
  bcd_interval_timer #(.CLK_DIV(4), .NUM_DIGITS(4),
    .MAX_BCD(16'h9999), .WRAP_EN(1'b1))
    dut_c (.CLOCK_50_I(clk), .resetn(rst_n), .tif(ifc));

  typedef struct {
    int div; int cnt; bit done; bit tick; bit wrap; bit err;
  } mdl_t;
  typedef struct { int clk_div; int maxv; bit wrap_en; } cfg_t;
  typedef struct {
    bit clr; bit ld; logic [7:0] lv; logic [7:0] ec; bit eerr;
  } vec_t;

  mdl_t m [3];
  cfg_t cf[3];
  int   ndg[3];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycno = 0;

  function automatic logic [31:0] to_bcd(int v, int nd);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(logic [31:0] v, int nd);
    int r;
    r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction

  function automatic bit is_bcd(logic [31:0] v, int nd);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < nd; i++) if (v[4*i+:4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Abstract model: count as an integer, terminal rules by arithmetic.
  function automatic mdl_t mnext(mdl_t s, cfg_t c, bit e, bit u,
                                 bit cl, bit l, logic [31:0] v, int nd);
    mdl_t n;
    bit   go, stp;
    int   nd_div, val;
    n = s;
    n.tick = 0; n.wrap = 0; n.err = 0;
    go = e && !s.done;
    stp = go && (s.div == c.clk_div - 1);
    nd_div = go ? (s.div + 1) % c.clk_div : s.div;
    val = from_bcd(v, nd);
    if (cl) begin
      n.div = 0; n.cnt = 0; n.done = 0;
    end else if (l) begin
      if (is_bcd(v, nd) && val <= c.maxv) begin
        n.cnt = val; n.div = 0; n.done = 0;
      end else begin
        n.err = 1; n.div = nd_div;
      end
    end else begin
      n.div = nd_div;
      if (stp) begin
        if ((u && s.cnt == c.maxv) || (!u && s.cnt == 0)) begin
          n.wrap = 1;
          if (c.wrap_en) begin
            n.tick = 1;
            n.cnt = u ? 0 : c.maxv;
          end else begin
            n.done = 1;
          end
        end else begin
          n.tick = 1;
          n.cnt = u ? s.cnt + 1 : s.cnt - 1;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] expv(mdl_t s, int nd);
    logic [31:0] b;
    b = to_bcd(s.cnt, nd);
    return {b[15:0], 12'h0, s.tick, s.wrap, s.done, s.err};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cycno, got, exp);
    end
  endtask

  task automatic cmp_all();
    chk("model_a", {8'h0, ifa.count_o, 12'h0, ifa.tick_o,
        ifa.wrap_o, ifa.done_o, ifa.load_err_o}, expv(m[0], 2));
    chk("model_b", {8'h0, ifb.count_o, 12'h0, ifb.tick_o,
        ifb.wrap_o, ifb.done_o, ifb.load_err_o}, expv(m[1], 2));
    chk("model_c", {ifc.count_o, 12'h0, ifc.tick_o,
        ifc.wrap_o, ifc.done_o, ifc.load_err_o}, expv(m[2], 4));
  endtask

  task automatic cyc();
    logic [31:0] msk;
    @(posedge clk);
    cycno++;
    for (int k = 0; k < 3; k++) begin
      msk = (32'd1 << (4 * ndg[k])) - 32'd1;
      m[k] = mnext(m[k], cf[k], en, up, clr, ld, lv & msk, ndg[k]);
    end
    #1;
    cmp_all();
  endtask

  task automatic mreset();
    for (int k = 0; k < 3; k++) m[k] = '{0, 0, 0, 0, 0, 0};
  endtask

  vec_t tbl[8];
  int   nt, nw;

  initial begin
    tbl[0] = '{1, 0, 8'h00, 8'h00, 0};
    tbl[1] = '{0, 1, 8'h42, 8'h42, 0};
    tbl[2] = '{0, 1, 8'h5A, 8'h42, 1};
    tbl[3] = '{0, 1, 8'h60, 8'h42, 1};
    tbl[4] = '{0, 1, 8'h59, 8'h59, 0};
    tbl[5] = '{0, 1, 8'h9F, 8'h59, 1};
    tbl[6] = '{1, 1, 8'h12, 8'h00, 0};
    tbl[7] = '{0, 1, 8'h42, 8'h42, 0};
    cf[0] = '{4, 59, 1'b1};   ndg[0] = 2;
    cf[1] = '{4, 59, 1'b0};   ndg[1] = 2;
    cf[2] = '{4, 9999, 1'b1}; ndg[2] = 4;
    mreset();
    en = 0; up = 1; clr = 0; ld = 0; lv = '0;

    #1 rst_n = 1'b0;
    #1;
    cmp_all();
    chk("reset_a", {24'h0, ifa.count_o}, 32'h0);
    #10 rst_n = 1'b1;

    // Up count through a full wrap.
    en = 1; up = 1;
    nt = 0; nw = 0;
    for (int i = 0; i < 240; i++) begin
      cyc();
      if (ifa.tick_o) nt++;
      if (ifa.wrap_o) begin
        nw++;
        chk("t1_wrap_cnt", {24'h0, ifa.count_o}, 32'h00);
      end
    end
    chk("t1_ticks", nt, 60);
    chk("t1_wraps", nw, 1);
    chk("t1_final", {24'h0, ifa.count_o}, 32'h00);

    // Down count with borrow and wrap to MAX.
    ld = 1; lv = 32'h10; up = 0;
    cyc();
    ld = 0;
    chk("t2_load", {24'h0, ifa.count_o}, 32'h10);
    repeat (4) cyc();
    chk("t2_borrow", {24'h0, ifa.count_o}, 32'h09);
    repeat (36) cyc();
    chk("t2_zero", {24'h0, ifa.count_o}, 32'h00);
    nw = 0;
    repeat (4) begin
      cyc();
      if (ifa.wrap_o) nw++;
    end
    chk("t2_wraps", nw, 1);
    chk("t2_max", {24'h0, ifa.count_o}, 32'h59);

    // One-shot down to zero on dut_b.
    ld = 1; lv = 32'h03;
    cyc();
    ld = 0;
    chk("t3_load", {24'h0, ifb.count_o}, 32'h03);
    repeat (12) cyc();
    chk("t3_zero", {23'h0, ifb.done_o, ifb.count_o}, 32'h000);
    nw = 0;
    repeat (4) begin
      cyc();
      if (ifb.wrap_o) nw++;
    end
    chk("t3_wrap", nw, 1);
    chk("t3_done", {31'h0, ifb.done_o}, 32'h1);
    nt = 0; nw = 0;
    repeat (20) begin
      cyc();
      if (ifb.tick_o) nt++;
      if (ifb.wrap_o) nw++;
    end
    chk("t3_hold", {23'h0, ifb.done_o, ifb.count_o}, 32'h100);
    chk("t3_quiet", nt + nw, 0);
    clr = 1;
    cyc();
    clr = 0; up = 1;
    chk("t3_clr", {31'h0, ifb.done_o}, 32'h0);
    repeat (4) cyc();
    chk("t3_resume", {24'h0, ifb.count_o}, 32'h01);

    // Pause preserves divider phase; clear beats load and step.
    ld = 1; lv = 32'h25;
    cyc();
    ld = 0;
    repeat (2) cyc();
    en = 0;
    repeat (10) cyc();
    chk("t4_frozen", {24'h0, ifa.count_o}, 32'h25);
    en = 1;
    cyc();
    chk("t4_notick", {31'h0, ifa.tick_o}, 32'h0);
    cyc();
    chk("t4_tick", {23'h0, ifa.tick_o, ifa.count_o}, 32'h126);
    repeat (3) cyc();
    clr = 1; ld = 1; lv = 32'h33;
    cyc();
    clr = 0; ld = 0;
    chk("t4_prio", {23'h0, ifa.tick_o, ifa.count_o}, 32'h000);

    // Constant vectors: load validation while paused.
    en = 0;
    for (int i = 0; i < 8; i++) begin
      clr = tbl[i].clr; ld = tbl[i].ld; lv = {24'h0, tbl[i].lv};
      cyc();
      chk($sformatf("vec%0d", i),
          {23'h0, ifa.load_err_o, ifa.count_o},
          {23'h0, tbl[i].eerr, tbl[i].ec});
    end
    clr = 0; ld = 0; en = 1; up = 1;
    repeat (3) cyc();
    chk("t5_div0", {23'h0, ifa.tick_o, ifa.count_o}, 32'h042);
    cyc();
    chk("t5_tick", {23'h0, ifa.tick_o, ifa.count_o}, 32'h143);

    // Four-digit carry, then async reset mid-interval.
    ld = 1; lv = 32'h0999;
    cyc();
    ld = 0;
    chk("t6_load", {16'h0, ifc.count_o}, 32'h0999);
    chk("t6_err_a", {31'h0, ifa.load_err_o}, 32'h1);
    repeat (4) cyc();
    chk("t6_carry", {16'h0, ifc.count_o}, 32'h1000);
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1;
    mreset();
    cmp_all();
    chk("t6_rst_c", {ifc.count_o, 12'h0, ifc.tick_o, ifc.wrap_o,
        ifc.done_o, ifc.load_err_o}, 32'h0);
    #4 rst_n = 1'b1;

    // Random run against the model.
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom % 8) != 0;
      if (($urandom % 16) == 0) up = ~up;
      clr = ($urandom % 64) == 0;
      ld  = ($urandom % 24) == 0;
      lv  = ($urandom % 2) ? to_bcd(int'($urandom % 10000), 4)
                           : $urandom;
      cyc();
    end
    clr = 0; ld = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bcd_interval_timer.md
Name: bcd_interval_timer

Overview:
Parametrised successor to the board's fixed 0–59 seconds counter. It divides the system clock into a programmable tick and drives an N-digit BCD counter that counts up or down between 0 and a BCD terminal value. It supports load, clear, pause, and either wrap-around or stop-at-terminal (one-shot) operation. It sits between the board switches/pushbuttons and the 7-segment hex converters.

Parameters:
CLK_DIV, 50000000, system-clock cycles per tick; must be ≥ 2.
NUM_DIGITS, 2, number of BCD digits; range 1–8.
MAX_BCD, 8'h59, terminal count as packed BCD, width 4*NUM_DIGITS; every nibble must be ≤ 9.
WRAP_EN, 1, selects the terminal behaviour. 1 = wrap-around; 0 = one-shot, stop at the terminal value.

Ports:
CLOCK_50_I  in  1  system clock, 50 MHz.
resetn  in  1  asynchronous active-low reset.
enable_i  in  1  1 = divider and counter run; 0 = pause.
up_down_i  in  1  1 = count up; 0 = count down.
clear_i  in  1  synchronous clear.
load_i  in  1  synchronous load strobe.
load_value_i  in  4*NUM_DIGITS  BCD value to load.
count_o  out  4*NUM_DIGITS  current BCD count.
tick_o  out  1  one-cycle pulse when the count steps.
wrap_o  out  1  one-cycle pulse on terminal crossing.
done_o  out  1  level; one-shot terminal reached (WRAP_EN=0 only).
load_err_o  out  1  one-cycle pulse when a load is rejected.

Behaviour:
Reset (resetn=0, asynchronous):
- divider = 0; count_o = 0.
- tick_o, wrap_o, done_o, load_err_o = 0.
- FSM = RUN.

Divider:
- Width is $clog2(CLK_DIV).
- While enable_i=1 and FSM=RUN, it counts 0 … CLK_DIV-1 and then returns to 0.
- The internal step is asserted when divider == CLK_DIV-1.
- While enable_i=0 it holds its value, so the tick phase is preserved across a pause.

Per-cycle priority (highest first): clear_i > load_i > step.
- clear_i:
  - divider = 0, count = 0, done_o = 0, FSM = RUN.
  - No tick_o or wrap_o.
- load_i:
  - If any nibble of load_value_i is > 9, or the value exceeds MAX_BCD, the load is rejected: count is unchanged and load_err_o pulses on the next cycle.
  - Otherwise count = load_value_i, divider = 0, done_o = 0, FSM = RUN.
  - Either way, any step in the same cycle is suppressed.
- step, up (up_down_i=1):
  - If count == MAX_BCD: WRAP_EN=1 gives count = 0 and a wrap_o pulse; WRAP_EN=0 follows the DONE rule below.
  - Otherwise: BCD increment with ripple carry; a digit at 9 becomes 0 and carries into the next digit.
- step, down (up_down_i=0):
  - If count == 0: WRAP_EN=1 gives count = MAX_BCD and a wrap_o pulse; WRAP_EN=0 follows the DONE rule below.
  - Otherwise: BCD decrement with borrow; a digit at 0 becomes 9 and borrows from the next digit.
- Registered outputs: tick_o, wrap_o and the new count_o appear on the same clock edge, one cycle after the step condition. tick_o pulses on every accepted step, including a wrapping one.

FSM:
- States: RUN and DONE. DONE is used only when WRAP_EN=0.
- RUN → DONE: a step arrives while count is already at the terminal for the current direction (MAX_BCD going up, 0 going down).
- In DONE:
  - count holds at the terminal, done_o = 1, the divider is frozen, no tick_o.
  - wrap_o pulses once on entry.
- DONE → RUN: only on clear_i or an accepted load_i.
- A direction change while in DONE has no effect.

Other rules:
- Changing up_down_i mid-interval takes effect at the next step; the divider phase is unaffected.
- enable_i=0 suppresses the step even when the divider sits at CLK_DIV-1; clear and load still act while paused.
- Reset asserted mid-operation returns every output to its reset value immediately, with no clock needed.
- count_o always holds valid BCD ≤ MAX_BCD.

Test Plan:
1. CLK_DIV=4, defaults, enable=1, up, run 60 steps.
   - tick_o every 4 cycles; count goes 00, 01 … 09, 10 … 59, 00.
   - wrap_o pulses exactly once, coincident with 59→00.
2. Down count from load 8'h10.
   - Count goes 10, 09 … 00, then 59 with a wrap_o pulse.
   - The 10→09 step exercises the borrow.
3. WRAP_EN=0, down, load 8'h03.
   - Count goes 03, 02, 01, 00; the next step asserts done_o=1 and a single wrap_o pulse.
   - Count holds 00 for 20 further cycles; a clear_i then gives done_o=0 and counting resumes.
4. Pause and priority.
   - Drop enable_i with the divider at 2 for 10 cycles: count frozen; the next tick arrives 2 cycles after re-enable.
   - clear_i and load_i asserted together with a step: count = 00, no tick_o.
5. Invalid load.
   - load_value_i = 8'h5A or 8'h60: load_err_o pulses one cycle and count is unchanged.
   - load_value_i = 8'h42: count = 42 and the divider restarts from 0.
6. NUM_DIGITS=4, MAX_BCD=16'h9999, up, load 16'h0999, one step.
   - Count = 1000, carry through three digits.
   - Assert resetn=0 mid-interval: all outputs go to 0 asynchronously.
